// File: rtl/motoro301_pkg.sv
// Shared definitions for the six-step motor commutation controller:
// state encoding, timing constants and the six-step switch table.
package motoro301_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } motorState_t;

    localparam int unsigned DEAD_CYC = 50;
    localparam int unsigned PER_DEF  = 100_000;
    localparam int unsigned PER_STEP = 10_000;
    localparam int unsigned PER_MIN  = 20_000;
    localparam int unsigned PER_MAX  = 500_000;
    localparam int unsigned BAUD_DIV = 434;
    localparam int unsigned HB_CYC   = 25_000_000;

    // Counter widths sized for the default constants above.
    localparam int PER_W  = 20;
    localparam int DEAD_W = 8;
    localparam int HB_W   = 25;
    localparam int BAUD_W = 16;

    // Switch vector layout: {aHP, bHP, cHP, aLN, bLN, cLN}
    typedef logic [5:0] swBits_t;

    // Six-step commutation table; an out-of-range index drives nothing.
    function automatic swBits_t stepDrive(input logic [2:0] idx);
        case (idx)
            3'd0:    return 6'b100_010;
            3'd1:    return 6'b100_001;
            3'd2:    return 6'b010_001;
            3'd3:    return 6'b010_100;
            3'd4:    return 6'b001_100;
            3'd5:    return 6'b001_010;
            default: return 6'b000_000;
        endcase
    endfunction

    // Step index advance, modulo 6, in either rotation direction.
    function automatic logic [2:0] advanceStep(input logic [2:0] idx, input logic rev);
        if (rev) begin
            return (idx == 3'd0) ? 3'd5 : idx - 3'd1;
        end
        return (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/motoro301_uart_tx.sv
// 8N1 UART transmitter, LSB first. A start request seen while busy is ignored.
// Only built when MOTORO301_UART_STATUS_EN is defined.
`ifdef MOTORO301_UART_STATUS_EN
module motoro301_uart_tx
    import motoro301_pkg::*;
#(
    parameter int unsigned P_BAUD_DIV = BAUD_DIV
) (
    input  logic       clk50mhz,
    input  logic       nReset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(P_BAUD_DIV - 1);

    logic [9:0]        shiftReg;
    logic [3:0]        bitCnt;
    logic [BAUD_W-1:0] baudCnt;
    logic              busyReg;

    // Frame shifter: load {stop, data, start}, shift one bit per baud period.
    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            shiftReg <= '1;
            bitCnt   <= '0;
            baudCnt  <= '0;
            busyReg  <= 1'b0;
        end else if (!busyReg) begin
            if (start) begin
                shiftReg <= {1'b1, data, 1'b0};
                bitCnt   <= 4'd9;
                baudCnt  <= BAUD_LOAD;
                busyReg  <= 1'b1;
            end
        end else if (baudCnt == '0) begin
            baudCnt <= BAUD_LOAD;
            if (bitCnt == 4'd0) begin
                busyReg <= 1'b0;
            end else begin
                shiftReg <= {1'b1, shiftReg[9:1]};
                bitCnt   <= bitCnt - 4'd1;
            end
        end else begin
            baudCnt <= baudCnt - BAUD_W'(1);
        end
    end

    assign busy = busyReg;
    assign tx   = shiftReg[0];

endmodule
`endif

// File: rtl/motoro301_rtl_top.sv
// Six-step BLDC commutation controller with dead-time insertion,
// adjustable step period and status LEDs.
// Optional feature: MOTORO301_UART_STATUS_EN adds a UART status byte per step.
//
// state | meaning
// IDLE  | stopped, all switches off, step index held at 0
// DEAD  | dead-time between steps, all switches off
// RUN   | one six-step pattern driven for `period` cycles
// FAULT | emergency stop latched, waits for start and stop both low
module motoro301_rtl_top
    import motoro301_pkg::*;
#(
    parameter int unsigned P_DEAD_CYC = DEAD_CYC,
    parameter int unsigned P_PER_DEF  = PER_DEF,
    parameter int unsigned P_PER_STEP = PER_STEP,
    parameter int unsigned P_PER_MIN  = PER_MIN,
    parameter int unsigned P_PER_MAX  = PER_MAX,
    parameter int unsigned P_HB_CYC   = HB_CYC
) (
    input  logic       clk50mhz,
    input  logic       nReset,
    input  logic       m3start,
    input  logic       m3forceStop,
    input  logic       m3invRotate,
    input  logic       m3freqINC,
    input  logic       m3freqDEC,
    output logic       aHP,
    output logic       bHP,
    output logic       cHP,
    output logic       aLN,
    output logic       bLN,
    output logic       cLN,
    output logic       tp01,
    output logic       tp02,
    output logic       uTx,
    output logic [3:0] led4
);

    localparam logic [PER_W-1:0]  PER_DEF_V  = PER_W'(P_PER_DEF);
    localparam logic [PER_W-1:0]  PER_STEP_V = PER_W'(P_PER_STEP);
    localparam logic [PER_W-1:0]  PER_MIN_V  = PER_W'(P_PER_MIN);
    localparam logic [PER_W-1:0]  PER_MAX_V  = PER_W'(P_PER_MAX);
    localparam logic [DEAD_W-1:0] DEAD_LOAD  = DEAD_W'(P_DEAD_CYC - 1);
    localparam logic [HB_W-1:0]   HB_LOAD    = HB_W'(P_HB_CYC - 1);

    // bit order: {freqDEC, freqINC, invRotate, forceStop, start}
    logic [4:0] syncA, syncB;
    logic       startS, stopS, invS, incS, decS;
    logic       incD, decD, incEdge, decEdge;

    motorState_t state, nextState;
    logic        dead2run;
    logic [DEAD_W-1:0] deadTmr;
    logic [PER_W-1:0]  runTmr;
    logic [PER_W-1:0]  periodReg;
    logic        fromRun;
    logic [2:0]  stepIdx, stepNext;
    logic        dirReg, dirNext;
    swBits_t     swReg;
    logic        tp01Reg, tp02Reg, ledRun, ledFault, hbReg;
    logic [HB_W-1:0] hbTmr;

    // Two-flop synchronizers for all asynchronous control inputs.
    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            syncA <= '0;
            syncB <= '0;
        end else begin
            syncA <= {m3freqDEC, m3freqINC, m3invRotate, m3forceStop, m3start};
            syncB <= syncA;
        end
    end

    assign {decS, incS, invS, stopS, startS} = syncB;

    // Delayed copies for rising-edge detection of the frequency buttons.
    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            incD <= 1'b0;
            decD <= 1'b0;
        end else begin
            incD <= incS;
            decD <= decS;
        end
    end

    assign incEdge = incS & ~incD;
    assign decEdge = decS & ~decD;

    // Step period with saturation; simultaneous edges cancel.
    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            periodReg <= PER_DEF_V;
        end else if (incEdge && !decEdge) begin
            periodReg <= (periodReg <= PER_MIN_V + PER_STEP_V) ? PER_MIN_V : periodReg - PER_STEP_V;
        end else if (decEdge && !incEdge) begin
            periodReg <= (periodReg >= PER_MAX_V - PER_STEP_V) ? PER_MAX_V : periodReg + PER_STEP_V;
        end
    end

    // State register.
    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; forceStop overrides every other transition.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (startS && !stopS) nextState = DEAD;
            DEAD:    if (!startS) nextState = IDLE;
                     else if (deadTmr == '0) nextState = RUN;
            RUN:     if (!startS) nextState = IDLE;
                     else if (runTmr == '0) nextState = DEAD;
            FAULT:   if (!startS && !stopS) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (stopS) nextState = FAULT;
    end

    assign dead2run = (state == DEAD) && (nextState == RUN);

    // Step index and direction: advance only when DEAD was entered from RUN.
    always_comb begin
        stepNext = stepIdx;
        dirNext  = dirReg;
        if (nextState == IDLE) begin
            stepNext = 3'd0;
        end else if (dead2run) begin
            dirNext = invS;
            if (fromRun) stepNext = advanceStep(stepIdx, invS);
        end
    end

    // Dead-time and step down-counters; each is loaded on entry to its state.
    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            deadTmr <= '0;
            runTmr  <= '0;
            fromRun <= 1'b0;
        end else begin
            if (nextState == DEAD && state != DEAD) begin
                deadTmr <= DEAD_LOAD;
                fromRun <= (state == RUN);
            end else if (state == DEAD && deadTmr != '0) begin
                deadTmr <= deadTmr - DEAD_W'(1);
            end
            if (dead2run) begin
                runTmr <= periodReg - PER_W'(1);
            end else if (state == RUN && runTmr != '0) begin
                runTmr <= runTmr - PER_W'(1);
            end
        end
    end

    // Registered outputs decoded from the next state so they line up with it.
    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            stepIdx  <= 3'd0;
            dirReg   <= 1'b0;
            swReg    <= '0;
            tp01Reg  <= 1'b0;
            tp02Reg  <= 1'b0;
            ledRun   <= 1'b0;
            ledFault <= 1'b0;
        end else begin
            stepIdx  <= stepNext;
            dirReg   <= dirNext;
            swReg    <= (nextState == RUN) ? stepDrive(stepNext) : '0;
            tp01Reg  <= tp01Reg ^ dead2run;
            tp02Reg  <= (nextState == DEAD);
            ledRun   <= (nextState == RUN) || (nextState == DEAD);
            ledFault <= (nextState == FAULT);
        end
    end

    // Heartbeat LED toggle.
    always_ff @(posedge clk50mhz or negedge nReset) begin
        if (!nReset) begin
            hbTmr <= HB_LOAD;
            hbReg <= 1'b0;
        end else if (hbTmr == '0) begin
            hbTmr <= HB_LOAD;
            hbReg <= ~hbReg;
        end else begin
            hbTmr <= hbTmr - HB_W'(1);
        end
    end

    assign {aHP, bHP, cHP, aLN, bLN, cLN} = swReg;
    assign tp01 = tp01Reg;
    assign tp02 = tp02Reg;
    assign led4 = {hbReg, ledFault, dirReg, ledRun};

`ifdef MOTORO301_UART_STATUS_EN
    logic       uartBusy;
    logic [7:0] uartData;

    assign uartData = {(nextState == RUN) || (nextState == DEAD), dirNext,
                       (nextState == FAULT), 2'b00, stepNext};

    motoro301_uart_tx uUart (
        .clk50mhz (clk50mhz),
        .nReset   (nReset),
        .start    (dead2run && !uartBusy),
        .data     (uartData),
        .busy     (uartBusy),
        .tx       (uTx)
    );
`else
    assign uTx = 1'b1;
`endif

endmodule

// File: tb/tb_motoro301_rtl_top.sv
module tb_motoro301_rtl_top;
    import motoro301_pkg::*;

    localparam int DEAD  = 50;
    localparam int PDEF  = 1000;
    localparam int PSTEP = 100;
    localparam int PMIN  = 200;
    localparam int PMAX  = 5000;
    localparam int HB    = 2000;

    logic clk50mhz = 1'b0;
    logic nReset = 1'b0;
    logic m3start = 1'b0, m3forceStop = 1'b0, m3invRotate = 1'b0;
    logic m3freqINC = 1'b0, m3freqDEC = 1'b0;
    logic aHP, bHP, cHP, aLN, bLN, cLN, tp01, tp02, uTx;
    logic [3:0] led4;

    always #5 clk50mhz = ~clk50mhz;

    motoro301_rtl_top #(
        .P_DEAD_CYC (DEAD), .P_PER_DEF (PDEF), .P_PER_STEP (PSTEP),
        .P_PER_MIN (PMIN), .P_PER_MAX (PMAX), .P_HB_CYC (HB)
    ) dut (
        .clk50mhz (clk50mhz), .nReset (nReset), .m3start (m3start),
        .m3forceStop (m3forceStop), .m3invRotate (m3invRotate),
        .m3freqINC (m3freqINC), .m3freqDEC (m3freqDEC),
        .aHP (aHP), .bHP (bHP), .cHP (cHP), .aLN (aLN), .bLN (bLN), .cLN (cLN),
        .tp01 (tp01), .tp02 (tp02), .uTx (uTx), .led4 (led4)
    );

    typedef struct { int step; int len; } exp_t;   // len 0: length not checked
    exp_t expQ[$];
    exp_t popped;

    int errors = 0, checks = 0;
    int overlapErr = 0, utxErr = 0;
    int deadCnt = 0, lastDead = 0, runCnt = 0, segStep = 0;
    logic [5:0] swNow, prevSw = '0;
    logic prevTp02 = 1'b0, prevTp01 = 1'b0;

    assign swNow = {aHP, bHP, cHP, aLN, bLN, cLN};

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int decodeStep(input logic [5:0] sw);
        case (sw)
            6'b100_010: return 0;
            6'b100_001: return 1;
            6'b010_001: return 2;
            6'b010_100: return 3;
            6'b001_100: return 4;
            6'b001_010: return 5;
            default:    return 7;
        endcase
    endfunction

    // Per-cycle safety checks and scoreboard of completed RUN segments.
    always @(negedge clk50mhz) begin
        if ((aHP & aLN) | (bHP & bLN) | (cHP & cLN)) overlapErr++;
        if ($countones(swNow[5:3]) > 1 || $countones(swNow[2:0]) > 1) overlapErr++;
`ifndef MOTORO301_UART_STATUS_EN
        if (uTx !== 1'b1) utxErr++;
`endif
        if (tp02) deadCnt++;
        else if (prevTp02) begin
            lastDead = deadCnt;
            deadCnt = 0;
        end
        if (swNow != 0 && prevSw == 0) begin
            check("deadLen", lastDead, DEAD);
            check("tp01Toggle", int'(tp01), int'(!prevTp01));
            segStep = decodeStep(swNow);
            runCnt = 0;
        end
        if (swNow != 0) runCnt++;
        if (swNow == 0 && prevSw != 0) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL extraStep: observed step %0d expected none", segStep);
            end else begin
                popped = expQ.pop_front();
                check("stepIdx", segStep, popped.step);
                if (popped.len != 0) check("runLen", runCnt, popped.len);
            end
        end
        prevSw = swNow;
        prevTp02 = tp02;
        prevTp01 = tp01;
    end

    task automatic push(input int step, input int len);
        exp_t e;
        e.step = step;
        e.len = len;
        expQ.push_back(e);
    endtask

    task automatic drain(input int maxCyc);
        int n = 0;
        while (expQ.size() != 0 && n < maxCyc) begin
            @(negedge clk50mhz);
            n++;
        end
        check("drainQueue", expQ.size(), 0);
    endtask

    task automatic waitRun(input int maxCyc);
        int n = 0;
        while (swNow == 0 && n < maxCyc) begin
            @(negedge clk50mhz);
            n++;
        end
        check("runStart", int'(swNow != 0), 1);
    endtask

    task automatic pulse(input logic inc, input logic dec);
        m3freqINC = inc;
        m3freqDEC = dec;
        repeat (4) @(negedge clk50mhz);
        m3freqINC = 1'b0;
        m3freqDEC = 1'b0;
        repeat (4) @(negedge clk50mhz);
    endtask

    initial begin
        int n;
        logic hbPrev;

        // Reset state
        repeat (3) @(negedge clk50mhz);
        check("rstSw", int'(swNow), 0);
        check("rstTp01", int'(tp01), 0);
        check("rstTp02", int'(tp02), 0);
        check("rstLed", int'(led4), 0);
        check("rstUtx", int'(uTx), 1);

        // Forward rotation from reset: steps 0..5 then wrap to 0
        m3start = 1'b1;
        nReset = 1'b1;
        for (int s = 0; s < 7; s++) push(s % 6, PDEF);
`ifdef MOTORO301_UART_STATUS_EN
        n = 0;
        while (uTx !== 1'b0 && n < 500) begin
            @(negedge clk50mhz);
            n++;
        end
        repeat (217) @(negedge clk50mhz);
        check("uartStart", int'(uTx), 0);
        for (int b = 0; b < 8; b++) begin
            repeat (434) @(negedge clk50mhz);
            check("uartBit", int'(uTx), (b == 7) ? 1 : 0);
        end
        repeat (434) @(negedge clk50mhz);
        check("uartStop", int'(uTx), 1);
`endif
        hbPrev = led4[3];
        n = 0;
        while (led4[3] === hbPrev && n < 2 * HB) begin
            @(negedge clk50mhz);
            n++;
        end
        hbPrev = led4[3];
        n = 0;
        while (led4[3] === hbPrev && n < 2 * HB) begin
            @(negedge clk50mhz);
            n++;
        end
        check("heartbeat", n, HB);
        check("ledRunning", int'(led4[0]), 1);
        check("ledDirFwd", int'(led4[1]), 0);
        drain(10000);
        m3start = 1'b0;
        repeat (10) @(negedge clk50mhz);
        check("idleLedRun", int'(led4[0]), 0);
        check("idleSw", int'(swNow), 0);

        // Reverse rotation: 0,5,4,3,2,1,0
        m3invRotate = 1'b1;
        repeat (5) @(negedge clk50mhz);
        m3start = 1'b1;
        push(0, PDEF);
        for (int s = 5; s >= 0; s--) push(s, PDEF);
        drain(10000);
        check("ledDirRev", int'(led4[1]), 1);
        m3start = 1'b0;
        m3invRotate = 1'b0;
        repeat (10) @(negedge clk50mhz);

        // Period adjust: 3 INC -> 700, 12 INC -> 200 (min), INC+DEC no-op, DEC -> 300
        m3start = 1'b1;
        push(0, PDEF);
        push(1, PDEF - 3 * PSTEP);
        waitRun(200);
        repeat (3) pulse(1'b1, 1'b0);
        drain(3000);
        push(2, PDEF - 3 * PSTEP);
        push(3, PMIN);
        waitRun(200);
        repeat (12) pulse(1'b1, 1'b0);
        drain(3000);
        push(4, PMIN);
        push(5, PMIN + PSTEP);
        waitRun(200);
        pulse(1'b1, 1'b1);
        pulse(1'b0, 1'b1);
        drain(3000);

        // Emergency stop mid-RUN and latched fault
        push(0, 0);
        waitRun(200);
        repeat (50) @(negedge clk50mhz);
        m3forceStop = 1'b1;
        n = 0;
        while (swNow != 0 && n < 10) begin
            @(negedge clk50mhz);
            n++;
        end
        check("stopLatency", int'(n <= 3), 1);
        check("stopSw", int'(swNow), 0);
        repeat (2) @(negedge clk50mhz);
        check("faultLed", int'(led4[2]), 1);
        check("faultLedRun", int'(led4[0]), 0);
        m3forceStop = 1'b0;
        repeat (20) @(negedge clk50mhz);
        check("faultHeldSw", int'(swNow), 0);
        check("faultHeldLed", int'(led4[2]), 1);
        check("faultHeldTp02", int'(tp02), 0);
        m3start = 1'b0;
        repeat (10) @(negedge clk50mhz);
        check("faultClear", int'(led4[2]), 0);
        m3start = 1'b1;
        push(0, PMIN + PSTEP);
        drain(3000);
        m3start = 1'b0;
        repeat (10) @(negedge clk50mhz);

        // Asynchronous reset mid-RUN; period returns to default afterwards
        m3start = 1'b1;
        push(0, 0);
        waitRun(200);
        repeat (100) @(negedge clk50mhz);
        #2 nReset = 1'b0;
        #1;
        check("asyncRstSw", int'(swNow), 0);
        check("asyncRstTp01", int'(tp01), 0);
        check("asyncRstLed", int'(led4), 0);
        repeat (3) @(negedge clk50mhz);
        nReset = 1'b1;
        push(0, PDEF);
        drain(3000);
        m3start = 1'b0;
        repeat (10) @(negedge clk50mhz);

        check("overlap", overlapErr, 0);
`ifndef MOTORO301_UART_STATUS_EN
        check("uTxIdle", utxErr, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motoro301_rtl_top.md
MOTORO301_RTL_TOP -- requirements
Module: motoro301_rtl_top

Interface
REQ-001 One clock and one reset: reset is asynchronous and active-low. Ports are clk50mhz and nReset.
REQ-002 clk50mhz  in  1  50 MHz system clock; all state on the rising edge.
REQ-003 nReset  in  1  asynchronous active-low reset.
REQ-004 m3start  in  1  run request; level-sensitive, active-high.
REQ-005 m3forceStop  in  1  emergency stop; active-high.
REQ-006 m3invRotate  in  1  0=forward, 1=reverse step order.
REQ-007 m3freqINC  in  1  rising edge shortens the step period.
REQ-008 m3freqDEC  in  1  rising edge lengthens the step period.
REQ-009 aHP/bHP/cHP  out  1 each  high-side switch on per phase; active-high.
REQ-010 aLN/bLN/cLN  out  1 each  low-side switch on per phase; active-high.
REQ-011 tp01  out  1  toggles at every commutation step.
REQ-012 tp02  out  1  high during every dead-time interval.
REQ-013 uTx  out  1  UART status output; idle high.
REQ-014 led4  out  4  [0] running, [1] direction, [2] fault latched, [3] heartbeat.

Function
REQ-015 All five m3* inputs SHALL pass through 2-flop synchronizers; freqINC and freqDEC use rising-edge detection after sync.
REQ-016 FSM states: IDLE, DEAD, RUN, FAULT.
REQ-017 State transitions:
- IDLE->DEAD when synced start=1 and forceStop=0.
- DEAD->RUN after exactly 50 cycles.
- RUN->DEAD when the step timer reaches the period.
- Any state->FAULT on synced forceStop=1.
- FAULT->IDLE only when synced start=0 and forceStop=0.
- RUN/DEAD->IDLE when synced start=0.
REQ-018 Outputs in IDLE, DEAD and FAULT: all six switch outputs 0, registered, within 1 cycle of the state change.
REQ-019 Six-step table, index 0..5 (H=high side on, L=low side on):
- step 0: aHP, bLN
- step 1: aHP, cLN
- step 2: bHP, cLN
- step 3: bHP, aLN
- step 4: cHP, aLN
- step 5: cHP, bLN
All other switch outputs are 0.
REQ-020 On each DEAD->RUN after a RUN->DEAD, the step index SHALL advance: +1 mod 6 when invRotate=0, -1 mod 6 when invRotate=1. invRotate is sampled only at this boundary.
REQ-021 The first RUN after IDLE SHALL use step 0.
REQ-022 Step timing: the timer counts RUN cycles. A step lasts exactly `period` RUN cycles plus 50 dead cycles.
REQ-023 Step period:
- reset value 100_000 cycles (2 ms; 12 ms electrical period).
- INC edge: -10_000; DEC edge: +10_000.
- saturates at 20_000 minimum and 500_000 maximum.
- a new value takes effect from the next step.
- simultaneous INC and DEC edges: no change.
REQ-024 xHP and xLN of the same phase SHALL never be 1 in the same cycle, including at reset, fault and direction change.
REQ-025 tp01 SHALL toggle on each DEAD->RUN transition. tp02 SHALL equal (state==DEAD).
REQ-026 LEDs:
- led4[0] = state is RUN or DEAD.
- led4[1] = direction last sampled.
- led4[2] = state is FAULT.
- led4[3] toggles every 25_000_000 cycles.

Reset
REQ-027 While nReset=0:
- state IDLE, step 0, period 100_000, timers 0.
- all six switch outputs 0; tp01=0, tp02=0.
- led4=0, uTx=1, UART idle.
REQ-028 Reset asserted mid-RUN SHALL force all switch outputs to 0 asynchronously.

Configuration
REQ-029 Macro MOTORO301_UART_STATUS_EN, when defined, enables the UART status feature:
- uTx sends 115200 8N1 (divisor 434), LSB first.
- one byte per DEAD->RUN transition: {running, dir, fault, 2'b00, step[2:0]}.
REQ-030 A request arriving while a byte is still being sent SHALL be dropped.
REQ-031 Without MOTORO301_UART_STATUS_EN, uTx SHALL be constant 1 and no UART logic is built.

Structure
REQ-032 Package motoro301_pkg SHALL hold:
- the state enum and the six-step output table.
- DEAD_CYC=50, PER_DEF=100_000, PER_STEP=10_000, PER_MIN=20_000, PER_MAX=500_000.
- BAUD_DIV=434, HB_CYC=25_000_000.
REQ-033 One sub-module, motoro301_uart_tx (start/data/busy handshake), is instantiated only when MOTORO301_UART_STATUS_EN is defined.

Verification
REQ-034 Release reset, start=1 at t=0:
- tp02 high for 50 cycles, then aHP=bLN=1.
- next step (aHP, cLN) begins 100_050 cycles later.
- step order 0..5 repeats every 600_300 cycles.
REQ-035 invRotate=1 before start: sequence after step 0 is 5,4,3,2,1,0.
REQ-036 Three INC pulses during RUN:
- the next step's RUN length is 70_000 cycles.
- twelve INC pulses saturate at 20_000.
REQ-037 forceStop=1 mid-RUN:
- all switch outputs 0 within 3 cycles; led4[2]=1.
- remains stopped after forceStop=0 until start is cycled 0->1.
REQ-038 Every cycle of all scenarios: assert no xHP&xLN overlap and at most one HP and one LN high.
REQ-039 With MOTORO301_UART_STATUS_EN defined: the first step decodes byte 0x80 on uTx at 434 cycles/bit; without the macro, uTx stays 1 throughout.
